// File: rtl/backdoor_rsp.sv
// backdoor_rsp: bank of NUM_REGS registers with a backdoor request/response port.
// A request is captured in IDLE, executed in a single EXEC cycle and answered in
// RESP, which holds the response until bd_rsp_ready. Hardware strobes (hw_we)
// update the registers in parallel; a backdoor write in the same cycle wins.
// Optional feature macro: BACKDOOR_RSP_FORCE_EN enables per-register force flags
// (FORCE/RELEASE opcodes). When undefined, FORCE/RELEASE answer with err=1.
module backdoor_rsp #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bd_req_valid,
    output logic                       bd_req_ready,
    input  logic [1:0]                 bd_req_op,
    input  logic [ADDR_W-1:0]          bd_req_addr,
    input  logic [DATA_W-1:0]          bd_req_wdata,
    output logic                       bd_rsp_valid,
    input  logic                       bd_rsp_ready,
    output logic [DATA_W-1:0]          bd_rsp_rdata,
    output logic                       bd_rsp_err,
    input  logic [NUM_REGS-1:0]        hw_we,
    input  logic [NUM_REGS*DATA_W-1:0] hw_wdata,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        forced
);

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_FORCE   = 2'd2;
    localparam logic [1:0] OP_RELEASE = 2'd3;

    // One extra bit so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic                w_accept;
    logic                w_rsp_done;
    logic                w_exec;

    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [DATA_W-1:0]   r_regs      [NUM_REGS];
    logic [DATA_W-1:0]   w_regs_next [NUM_REGS];

    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_addr_ok;
    logic [NUM_REGS-1:0] w_sel;
    logic [DATA_W-1:0]   w_rd_mux;
    logic                w_is_read;
    logic                w_is_write;
    logic                w_is_force;
    logic                w_is_release;
    logic                w_op_err;
    logic                w_req_err;
    logic [NUM_REGS-1:0] w_bd_load;
    logic [NUM_REGS-1:0] w_hw_ok;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StExec;
            StExec:  w_state_next = StResp;
            StResp:  if (w_rsp_done) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs and handshake qualifiers
    always_comb begin
        bd_req_ready = 1'b0;
        bd_rsp_valid = 1'b0;
        w_exec       = 1'b0;
        unique case (r_state)
            StIdle:  bd_req_ready = rst_n;
            StExec:  w_exec       = 1'b1;
            StResp:  bd_rsp_valid = 1'b1;
            default: ;
        endcase
        w_accept   = bd_req_valid & bd_req_ready;
        w_rsp_done = bd_rsp_valid & bd_rsp_ready;
    end

    // Request holding registers, loaded on the request handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= OP_READ;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= bd_req_op;
            r_addr  <= bd_req_addr;
            r_wdata <= bd_req_wdata;
        end
    end

    // Address decode and read mux over the held address
    always_comb begin
        w_addr_ok = ({1'b0, r_addr} < NUM_REGS_W);
        w_rd_mux  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_sel[i] = (r_addr == ADDR_W'(i));
            if (w_sel[i]) begin
                w_rd_mux = r_regs[i];
            end
        end
    end

    // Opcode decode, error detection and backdoor load strobes
    always_comb begin
        w_is_read    = (r_op == OP_READ);
        w_is_write   = (r_op == OP_WRITE);
        w_is_force   = (r_op == OP_FORCE);
        w_is_release = (r_op == OP_RELEASE);
`ifdef BACKDOOR_RSP_FORCE_EN
        w_op_err     = 1'b0;
`else
        w_op_err     = w_is_force | w_is_release;
`endif
        w_req_err    = ~w_addr_ok | w_op_err;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_bd_load[i] = w_exec & w_sel[i] & ~w_req_err & (w_is_write | w_is_force);
        end
    end

    // Response registers, computed at the end of EXEC and held through RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_exec) begin
            r_rsp_rdata <= (w_is_read && !w_req_err) ? w_rd_mux : '0;
            r_rsp_err   <= w_req_err;
        end
    end

    assign bd_rsp_rdata = r_rsp_rdata;
    assign bd_rsp_err   = r_rsp_err;

`ifdef BACKDOOR_RSP_FORCE_EN
    logic [NUM_REGS-1:0] r_forced;
    logic [NUM_REGS-1:0] w_forced_next;

    // Force flag next state: FORCE sets, RELEASE clears the addressed flag
    always_comb begin
        w_forced_next = r_forced;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_exec && w_sel[i] && !w_req_err) begin
                if (w_is_force) begin
                    w_forced_next[i] = 1'b1;
                end else if (w_is_release) begin
                    w_forced_next[i] = 1'b0;
                end
            end
        end
    end

    // Force flag storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_forced <= '0;
        end else begin
            r_forced <= w_forced_next;
        end
    end

    // The current flag gates hw_we, so a RELEASE only lets hw updates in next cycle
    assign w_hw_ok = hw_we & ~r_forced;
    assign forced  = r_forced;
`else
    assign w_hw_ok = hw_we;
    assign forced  = '0;
`endif

    // Register next state: backdoor load has priority over the hardware strobe
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_regs_next[i] = r_regs[i];
            if (w_bd_load[i]) begin
                w_regs_next[i] = r_wdata;
            end else if (w_hw_ok[i]) begin
                w_regs_next[i] = hw_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= w_regs_next[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule
